// File: rtl/led_framebuf.sv
// ============================================================================
// Module  : led_framebuf
// Purpose : Double-buffered 4x8 LED frame store with frame-synchronous publish
//           and a stepped PWM brightness fade. Macro LED_FRAMEBUF_COPY_EN
//           selects copy-on-swap instead of ping-pong buffer exchange.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_framebuf #(
    parameter int FRAME_DIV = 12000,
    parameter int FADE_DIV  = 8
) (
    input  logic       clk12MHz,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic [7:0] wr_mask,
    input  logic       commit,
    output logic       commit_pending,
    output logic       frame_tick,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4,
    input  logic [2:0] brightness,
    output logic [2:0] leds_pwm
);

    localparam logic [15:0] c_frame_last = 16'(FRAME_DIV - 1);
    localparam logic [7:0]  c_fade_last  = 8'(FADE_DIV - 1);

    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [7:0]      fade_cnt_q, fade_cnt_d;
    logic            alive_q, pend_q, pend_d;
    logic [2:0]      pwm_q, pwm_d;
    logic [3:0][7:0] front_q, front_d;
    logic [3:0][7:0] back_q, back_d;
    logic            w_swap;

    assign frame_tick     = (frame_cnt_q == c_frame_last);
    assign w_swap         = frame_tick && pend_q;
    assign wr_ready       = alive_q && !w_swap;
    assign commit_pending = pend_q;
    assign leds_pwm       = pwm_q;
    assign leds1          = front_q[0];
    assign leds2          = front_q[1];
    assign leds3          = front_q[2];
    assign leds4          = front_q[3];

    always_comb begin
        frame_cnt_d = frame_tick ? 16'd0 : frame_cnt_q + 16'd1;
        fade_cnt_d  = fade_cnt_q;
        pwm_d       = pwm_q;
        front_d     = front_q;
        back_d      = back_q;
        pend_d      = pend_q | commit;

        if (wr_valid && wr_ready) begin
            back_d[wr_row] = (back_q[wr_row] & ~wr_mask) | (wr_data & wr_mask);
        end

        // A commit arriving on the swap cycle itself queues the next publish.
        if (w_swap) begin
            front_d = back_q;
`ifndef LED_FRAMEBUF_COPY_EN
            back_d  = front_q;
`endif
            pend_d  = commit;
        end

        if (frame_tick) begin
            if (fade_cnt_q == c_fade_last) begin
                fade_cnt_d = 8'd0;
                if (pwm_q < brightness) begin
                    pwm_d = pwm_q + 3'd1;
                end else if (pwm_q > brightness) begin
                    pwm_d = pwm_q - 3'd1;
                end
            end else begin
                fade_cnt_d = fade_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            fade_cnt_q  <= '0;
            alive_q     <= 1'b0;
            pend_q      <= 1'b0;
            pwm_q       <= '0;
            front_q     <= '0;
            back_q      <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            fade_cnt_q  <= fade_cnt_d;
            alive_q     <= 1'b1;
            pend_q      <= pend_d;
            pwm_q       <= pwm_d;
            front_q     <= front_d;
            back_q      <= back_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_framebuf.sv
// ============================================================================
// Module  : tb_led_framebuf
// Purpose : Randomised scoreboard bench for led_framebuf (FRAME_DIV=8, FADE_DIV=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_framebuf;

    localparam int FD = 8;
    localparam int FA = 2;

    logic       clk12MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] wr_mask = '0;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic       frame_tick;
    logic [7:0] leds1, leds2, leds3, leds4;
    logic [2:0] brightness = '0;
    logic [2:0] leds_pwm;

    led_framebuf #(.FRAME_DIV(FD), .FADE_DIV(FA)) dut (
        .clk12MHz(clk12MHz), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .commit(commit), .commit_pending(commit_pending), .frame_tick(frame_tick),
        .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
        .brightness(brightness), .leds_pwm(leds_pwm)
    );

    always #5 clk12MHz = ~clk12MHz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycles since reset, tick count, two row arrays.
    typedef struct packed {
        logic [31:0] leds;
        logic [2:0]  pwm;
        logic        pend;
    } exp_t;

    exp_t       sb_q[$];
    int         m_cyc = 0;
    int         m_ticks = 0;
    bit         m_alive = 0;
    bit         m_pend = 0;
    logic [7:0] m_front[4] = '{default: 8'h00};
    logic [7:0] m_back[4]  = '{default: 8'h00};
    logic [7:0] m_tmp[4];
    logic [2:0] m_pwm = '0;
    bit         exp_ready = 0;
    bit         exp_tick = 0;

    function automatic logic [31:0] front_word();
        return {m_front[3], m_front[2], m_front[1], m_front[0]};
    endfunction

    initial forever begin
        @(posedge clk12MHz or negedge rst_n);
        if (!rst_n) begin
            m_cyc = 0; m_ticks = 0; m_alive = 0; m_pend = 0; m_pwm = '0;
            m_front = '{default: 8'h00};
            m_back  = '{default: 8'h00};
            sb_q.delete();
        end else begin
            bit tick, swap;
            tick = (m_cyc % FD) == FD - 1;
            swap = tick && m_pend;
            if (wr_valid && m_alive && !swap)
                m_back[wr_row] = (m_back[wr_row] & ~wr_mask) | (wr_data & wr_mask);
            if (swap) begin
                m_tmp = m_front;
                m_front = m_back;
`ifndef LED_FRAMEBUF_COPY_EN
                m_back = m_tmp;
`endif
            end
            m_pend = swap ? commit : (m_pend || commit);
            if (tick) begin
                m_ticks++;
                if (m_ticks % FA == 0) begin
                    if (m_pwm < brightness) m_pwm = m_pwm + 3'd1;
                    else if (m_pwm > brightness) m_pwm = m_pwm - 3'd1;
                end
                sb_q.push_back('{leds: front_word(), pwm: m_pwm, pend: m_pend});
            end
            m_alive = 1;
            m_cyc++;
        end
        exp_tick  = (m_cyc % FD) == FD - 1;
        exp_ready = m_alive && !(exp_tick && m_pend);
    end

    // Monitor: per-cycle handshake/display checks, scoreboard pop after each tick.
    bit prev_tick = 0;
    initial forever begin
        exp_t e;
        @(negedge clk12MHz);
        if (!rst_n) begin
            prev_tick = 0;
        end else begin
            chk("wr_ready", 64'(wr_ready), 64'(exp_ready));
            chk("frame_tick", 64'(frame_tick), 64'(exp_tick));
            chk("display", {28'd0, leds4, leds3, leds2, leds1, leds_pwm, commit_pending},
                {28'd0, front_word(), m_pwm, m_pend});
            if (prev_tick) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard_empty: got tick, expected none");
                end else begin
                    e = sb_q.pop_front();
                    chk("tick_state", {28'd0, leds4, leds3, leds2, leds1, leds_pwm, commit_pending},
                        {28'd0, e.leds, e.pwm, e.pend});
                end
            end
            prev_tick = frame_tick;
        end
    end

    task automatic do_write(input logic [1:0] r, input logic [7:0] d, input logic [7:0] m);
        bit seen = 0;
        wr_valid = 1; wr_row = r; wr_data = d; wr_mask = m;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = wr_ready;
            @(negedge clk12MHz);
        end
        wr_valid = 0;
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout: got no wr_ready, expected within 20 cycles");
        end
    endtask

    task automatic do_commit();
        commit = 1;
        @(negedge clk12MHz);
        commit = 0;
    endtask

    // Returns at the negedge following a frame_tick cycle.
    task automatic wait_tick();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            seen = frame_tick;
            @(negedge clk12MHz);
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL tick_timeout: got no frame_tick, expected within 40 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk12MHz);
        #3 rst_n = 0;
        #1;
        chk("async_reset_outputs",
            {23'd0, leds4, leds3, leds2, leds1, leds_pwm, commit_pending, frame_tick, wr_ready},
            64'd0);
        repeat (2) @(negedge clk12MHz);
        rst_n = 1;
    endtask

    initial begin
        logic [7:0] exp_row1;
        repeat (3) @(negedge clk12MHz);
        chk("reset_outputs",
            {23'd0, leds4, leds3, leds2, leds1, leds_pwm, commit_pending, frame_tick, wr_ready},
            64'd0);
        rst_n = 1;
        @(negedge clk12MHz);

        // Basic publish
        wait_tick();
        do_write(2'd0, 8'hA5, 8'hFF);
        do_commit();
        chk("leds1_before_tick", 64'(leds1), 64'h00);
        wait_tick();
        chk("leds1_after_tick", 64'(leds1), 64'hA5);
        chk("pending_cleared", 64'(commit_pending), 64'd0);

        // Masked merge
        do_write(2'd2, 8'hF0, 8'hFF);
        do_write(2'd2, 8'h0F, 8'h3C);
        do_write(2'd3, 8'h77, 8'h00);
        do_commit();
        wait_tick();
        chk("leds3_masked", 64'(leds3), 64'hCC);

        // Write held across a swap cycle
        do_commit();
        while (!(frame_tick && commit_pending)) @(negedge clk12MHz);
        do_write(2'd3, 8'h5A, 8'hFF);

        // Commit during the swap cycle defers to the next tick
        do_commit();
        for (int i = 0; i < 20 && !(frame_tick && commit_pending); i++) @(negedge clk12MHz);
        do_commit();
        chk("pending_after_swap_commit", 64'(commit_pending), 64'd1);
        wait_tick();
        chk("second_swap_done", 64'(commit_pending), 64'd0);

        // Copy versus ping-pong
        do_reset();
        wait_tick();
        do_write(2'd1, 8'h11, 8'hFF);
        do_commit();
        wait_tick();
        chk("leds2_first_swap", 64'(leds2), 64'h11);
        do_commit();
        wait_tick();
`ifdef LED_FRAMEBUF_COPY_EN
        exp_row1 = 8'h11;
`else
        exp_row1 = 8'h00;
`endif
        chk("leds2_second_swap", 64'(leds2), 64'(exp_row1));

        // Brightness fade
        do_reset();
        brightness = 3'd5;
        repeat (100) @(negedge clk12MHz);
        chk("pwm_up_to_5", 64'(leds_pwm), 64'd5);
        brightness = 3'd3;
        repeat (40) @(negedge clk12MHz);
        chk("pwm_down_to_3", 64'(leds_pwm), 64'd3);

        // Reset drops a queued commit
        do_write(2'd0, 8'hEE, 8'hFF);
        do_commit();
        chk("pending_before_reset", 64'(commit_pending), 64'd1);
        do_reset();
        repeat (20) @(negedge clk12MHz);
        chk("no_swap_after_reset", 64'({leds4, leds3, leds2, leds1}), 64'd0);

        // Randomised traffic
        for (int c = 0; c < 2500; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_row   = 2'($urandom);
            wr_data  = 8'($urandom);
            wr_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            commit   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) brightness = 3'($urandom);
            if (c == 1200) begin
                wr_valid = 0; commit = 0;
                do_reset();
            end
            @(negedge clk12MHz);
        end
        wr_valid = 0; commit = 0;
        repeat (10) @(negedge clk12MHz);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_framebuf.md
LED_FRAMEBUF -- requirements
Module: led_framebuf

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 12000, clk12MHz cycles per frame tick (1 ms); legal range 2..65535.
REQ-002 SHALL have parameter FADE_DIV, default 8, frame ticks per brightness step; legal range 1..255.
REQ-003 SHALL have port clk12MHz  in  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  in  1  row-write request.
REQ-006 SHALL have port wr_ready  out  1  row-write accept; a write is taken when wr_valid && wr_ready at a clock edge.
REQ-007 SHALL have port wr_row  in  2  back-buffer row index; 0 maps to leds1 and 3 maps to leds4.
REQ-008 SHALL have port wr_data  in  8  row data.
REQ-009 SHALL have port wr_mask  in  8  per-bit write enable.
REQ-010 SHALL have port commit  in  1  one-cycle request to publish the back buffer.
REQ-011 SHALL have port commit_pending  out  1  a publish is queued.
REQ-012 SHALL have port frame_tick  out  1  one-cycle frame strobe.
REQ-013 SHALL have ports leds1, leds2, leds3, leds4  out  8 each  front-buffer rows 0..3, feeding LedDisplay directly.
REQ-014 SHALL have port brightness  in  3  target PWM level.
REQ-015 SHALL have port leds_pwm  out  3  current PWM level, feeding LedDisplay leds_pwm.

Function
REQ-016 The frame counter SHALL count 0..FRAME_DIV-1 and wrap; frame_tick SHALL be high for exactly the cycle in which the counter equals FRAME_DIV-1.
REQ-017 A swap cycle SHALL be defined as a cycle with frame_tick high and commit_pending high.
REQ-018 wr_ready SHALL be high except during a swap cycle and except while the alive flag (REQ-030) is low.
REQ-019 An accepted write SHALL update back[wr_row] to (back & ~wr_mask) | (wr_data & wr_mask) at that edge.
REQ-020 A write with wr_mask = 0 SHALL be accepted and SHALL leave the back buffer unchanged.
REQ-021 commit high SHALL set commit_pending at the next edge; a repeated commit while already pending SHALL have no additional effect.
REQ-022 On a swap cycle the front buffer SHALL load the back buffer and commit_pending SHALL clear, both at the same edge.
REQ-023 The new leds1..leds4 values SHALL be visible the cycle after the swap cycle.
REQ-024 A commit asserted in a swap cycle SHALL leave commit_pending set after that edge, deferring the new publish to the next tick.
REQ-025 A commit asserted on a frame_tick cycle with commit_pending low SHALL NOT swap; it SHALL swap on the following tick.
REQ-026 leds1..leds4 SHALL change only on a swap edge or on reset.
REQ-027 The fade counter SHALL count frame ticks 0..FADE_DIV-1 and wrap.
REQ-028 On each fade wrap, leds_pwm SHALL move one step toward brightness (+1 or -1) and SHALL hold when equal, so it never overshoots or wraps 7 to 0.
REQ-029 A change of brightness SHALL NOT reset the fade counter.

Reset
REQ-030 With rst_n low, the front and back buffers, leds1..leds4, leds_pwm, commit_pending, frame_tick, both counters and the alive flag SHALL all be 0.
REQ-031 The alive flag SHALL set at the first edge after reset release, so wr_ready stays 0 for exactly that first edge.
REQ-032 Reset asserted mid-operation SHALL drop any queued commit and SHALL blank the display immediately, without waiting for a clock.

Configuration
REQ-033 With macro LED_FRAMEBUF_COPY_EN defined, a swap SHALL copy back to front and SHALL leave back unchanged (back == front afterwards, allowing incremental edits).
REQ-034 With LED_FRAMEBUF_COPY_EN undefined, a swap SHALL exchange the buffers, so back holds the previous front contents (ping-pong).
REQ-035 All other behaviour SHALL be identical in both builds.

Verification (FRAME_DIV=8, FADE_DIV=2)
REQ-036 Release reset; write row 0 with data 0xA5, mask 0xFF; commit -> leds1 stays 0x00 until the next frame_tick, then reads 0xA5; commit_pending reads 0.
REQ-037 Back row 2 = 0xF0; write data 0x0F, mask 0x3C; commit -> after the swap, leds3 = 0xCC.
REQ-038 Hold wr_valid through a swap cycle -> wr_ready is 0 for that single cycle and the write lands one cycle later.
REQ-039 Commit on a swap cycle -> commit_pending remains 1 and a second swap occurs 8 cycles later.
REQ-040 Write row 1 = 0x11, swap, then swap again with no writes -> with COPY_EN, leds2 = 0x11; without COPY_EN, leds2 = 0x00.
REQ-041 Set brightness 5 from leds_pwm 0 -> leds_pwm steps 1, 2, 3, 4, 5, one step per 16 cycles, then holds; then set brightness 3 -> leds_pwm steps 4, then 3.
REQ-042 Assert rst_n low mid-frame with commit_pending = 1 -> all outputs read 0 asynchronously; after release, no swap occurs.
